// File: rtl/addsub_pipe_if.sv
// rtl/addsub_pipe_if.sv - operand/result handshake bundle for the pipelined adder/subtractor
interface addsub_pipe_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, sub, sat, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, sat, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - skewed ripple-carry add/subtract pipeline with signed saturation
module addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input logic          clk,
   input logic          rst_n,
   addsub_pipe_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  r_q   [STAGES];
   logic              c_q   [STAGES];
   logic              sat_q [STAGES];
   logic [STAGES-1:0] v_q;

   logic [WIDTH-1:0]  src_a [STAGES];
   logic [WIDTH-1:0]  src_b [STAGES];
   logic [WIDTH-1:0]  src_r [STAGES];
   logic              src_c [STAGES];
   logic              src_s [STAGES];
   logic [WIDTH-1:0]  r_n   [STAGES];
   logic              c_n   [STAGES];
   logic [CHUNK:0]    part;

   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] load;
   logic              room;
   logic              raw_ov;

   // Walk from the output back: a stage advances when everything downstream can make room.
   always_comb begin
      adv  = '0;
      room = bus.out_ready;
      for (int k = LAST; k >= 0; k--) begin
         adv[k] = v_q[k] & room;
         room   = ~v_q[k] | room;
      end
   end

   assign bus.in_ready = rst_n & room;

   always_comb begin
      load    = '0;
      load[0] = bus.in_valid & bus.in_ready;
      for (int k = 1; k < STAGES; k++) begin
         load[k] = adv[k-1];
      end
   end

   // Stage k adds its own chunk; B is inverted once at entry so all stages are plain adders.
   always_comb begin
      part     = '0;
      src_a[0] = bus.a;
      src_b[0] = bus.sub ? ~bus.b : bus.b;
      src_r[0] = '0;
      src_c[0] = bus.sub | bus.cin;
      src_s[0] = bus.sat;
      for (int k = 1; k < STAGES; k++) begin
         src_a[k] = a_q[k-1];
         src_b[k] = b_q[k-1];
         src_r[k] = r_q[k-1];
         src_c[k] = c_q[k-1];
         src_s[k] = sat_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part = {1'b0, src_a[k][k*CHUNK +: CHUNK]} + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, src_c[k]};
         r_n[k] = src_r[k];
         r_n[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
         c_n[k] = part[CHUNK];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            r_q[k]   <= '0;
            c_q[k]   <= 1'b0;
            sat_q[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= load[k] | (v_q[k] & ~adv[k]);
            if (load[k]) begin
               a_q[k]   <= src_a[k];
               b_q[k]   <= src_b[k];
               r_q[k]   <= r_n[k];
               c_q[k]   <= c_n[k];
               sat_q[k] <= src_s[k];
            end
         end
      end
   end

   // Carry into the MSB is recovered from the MSB sum bit, so only the final carry travels.
   assign raw_ov        = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ r_q[LAST][WIDTH-1] ^ c_q[LAST];
   assign bus.out_valid = v_q[LAST];
   assign bus.cout      = c_q[LAST];
   assign bus.overflow  = raw_ov;
   assign bus.sum       = (sat_q[LAST] & raw_ov)
                        ? {a_q[LAST][WIDTH-1], {(WIDTH-1){~a_q[LAST][WIDTH-1]}}}
                        : r_q[LAST];
endmodule
